serial_word_receiver: RTL and testbench



---
 rtl/serial_word_receiver.sv | 131 +++++++++++++
 tb/tb_serial_word_receiver.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_word_receiver.sv
// Serial-to-parallel word receiver driven by upstream edge-detector pulses, with a ready/ack holding register.
// Optional sticky overrun detection is compiled in with SERIAL_RX_OVERRUN_EN.
module serial_word_receiver #(
    parameter int WORD_WIDTH = 8,
    parameter bit MSB_FIRST  = 1'b1
) (
    input  logic                  sys_clk,
    input  logic                  rst,
    input  logic                  data_in,
    input  logic                  sample_edge,
    input  logic                  frame_start,
    input  logic                  frame_end,
    input  logic                  data_ack,
    output logic [WORD_WIDTH-1:0] data_out,
    output logic                  data_ready,
    output logic                  busy,
    output logic                  overrun
);

    localparam int CNT_W = $clog2(WORD_WIDTH + 1);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WORD_WIDTH - 1);

    typedef enum logic {
        IDLE = 1'b0,
        RECV = 1'b1
    } state_t;

    state_t                state, next_state;
    logic [CNT_W-1:0]      bit_cnt, next_cnt;
    logic [WORD_WIDTH-1:0] shift_reg, next_shift, shift_base, shifted;
    logic                  d1, d2, d3;
    logic                  complete;

    // Three stages match the edge detector's latency, so d3 is the line value at the clock edge.
    // NOTE: sequential state always uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            d1 <= 1'b0;
            d2 <= 1'b0;
            d3 <= 1'b0;
        end else begin
            d1 <= data_in;
            d2 <= d1;
            d3 <= d2;
        end
    end

    // A restarting frame shifts into a cleared register so no stale bits survive.
    always_comb begin
        shift_base = frame_start ? '0 : shift_reg;
        if (MSB_FIRST)
            shifted = {shift_base[WORD_WIDTH-2:0], d3};
        else
            shifted = {d3, shift_base[WORD_WIDTH-1:1]};
    end

    // NOTE: every output of this block gets a default first, which keeps it free of inferred latches.
    always_comb begin
        next_state = state;
        next_cnt   = bit_cnt;
        next_shift = shift_reg;
        complete   = 1'b0;
        if (frame_start) begin
            next_state = RECV;
            if (sample_edge) begin
                next_shift = shifted;
                next_cnt   = CNT_W'(1);
            end else begin
                next_shift = '0;
                next_cnt   = '0;
            end
        end else if (state == RECV) begin
            if (sample_edge) begin
                next_shift = shifted;
                if (bit_cnt == LAST_BIT) begin
                    complete = 1'b1;
                    next_cnt = '0;
                end else begin
                    next_cnt = bit_cnt + CNT_W'(1);
                end
            end
            if (frame_end) begin
                next_state = IDLE;
                next_cnt   = '0;
            end
        end
    end

    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            bit_cnt   <= '0;
            shift_reg <= '0;
        end else begin
            state     <= next_state;
            bit_cnt   <= next_cnt;
            shift_reg <= next_shift;
        end
    end

    // A completion always wins over an acknowledge in the same cycle.
    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            data_out   <= '0;
            data_ready <= 1'b0;
        end else if (complete) begin
            data_out   <= shifted;
            data_ready <= 1'b1;
        end else if (data_ack) begin
            data_ready <= 1'b0;
        end
    end

    assign busy = (state == RECV);

`ifdef SERIAL_RX_OVERRUN_EN
    logic overrun_q;

    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst)
            overrun_q <= 1'b0;
        else if (complete && data_ready && !data_ack)
            overrun_q <= 1'b1;
    end

    assign overrun = overrun_q;
`else
    assign overrun = 1'b0;
`endif

endmodule

// File: tb/tb_serial_word_receiver.sv
// Directed testbench for serial_word_receiver: two instances (MSB-first and LSB-first) share stimulus.
// Overrun expectations follow SERIAL_RX_OVERRUN_EN.
module tb_serial_word_receiver;

    logic       sys_clk = 1'b0;
    logic       rst = 1'b1;
    logic       data_in = 1'b0;
    logic       sample_edge = 1'b0;
    logic       frame_start = 1'b0;
    logic       frame_end = 1'b0;
    logic       data_ack = 1'b0;
    logic [7:0] data_out_m, data_out_l;
    logic       data_ready_m, data_ready_l;
    logic       busy_m, busy_l;
    logic       overrun_m, overrun_l;

    int tests_run = 0;
    int tests_failed = 0;

`ifdef SERIAL_RX_OVERRUN_EN
    localparam bit OVR_EXP = 1'b1;
`else
    localparam bit OVR_EXP = 1'b0;
`endif

    always #5 sys_clk = ~sys_clk;

    serial_word_receiver #(.WORD_WIDTH(8), .MSB_FIRST(1'b1)) dut_msb (
        .sys_clk(sys_clk), .rst(rst), .data_in(data_in), .sample_edge(sample_edge),
        .frame_start(frame_start), .frame_end(frame_end), .data_ack(data_ack),
        .data_out(data_out_m), .data_ready(data_ready_m), .busy(busy_m), .overrun(overrun_m)
    );

    serial_word_receiver #(.WORD_WIDTH(8), .MSB_FIRST(1'b0)) dut_lsb (
        .sys_clk(sys_clk), .rst(rst), .data_in(data_in), .sample_edge(sample_edge),
        .frame_start(frame_start), .frame_end(frame_end), .data_ack(data_ack),
        .data_out(data_out_l), .data_ready(data_ready_l), .busy(busy_l), .overrun(overrun_l)
    );

    task automatic do_reset();
        @(negedge sys_clk);
        rst = 1'b1;
        @(negedge sys_clk);
        rst = 1'b0;
    endtask

    task automatic pulse_start();
        @(negedge sys_clk);
        frame_start = 1'b1;
        @(negedge sys_clk);
        frame_start = 1'b0;
    endtask

    task automatic pulse_end();
        @(negedge sys_clk);
        frame_end = 1'b1;
        @(negedge sys_clk);
        frame_end = 1'b0;
    endtask

    task automatic pulse_ack();
        @(negedge sys_clk);
        data_ack = 1'b1;
        @(negedge sys_clk);
        data_ack = 1'b0;
    endtask

    // Sends w[7] first, n bits; each sample_edge trails its data bit by three cycles,
    // consecutive edges are back-to-back. Returns on the negedge after the last edge is sampled.
    task automatic send(input logic [7:0] w, input int n, input bit start_first,
                        input bit end_last, input bit ack_last);
        for (int k = 0; k < n + 3; k++) begin
            @(negedge sys_clk);
            if (k < n) data_in = w[7-k];
            else       data_in = 1'b0;
            sample_edge = (k >= 3);
            frame_start = start_first && (k == 3);
            frame_end   = end_last && (k == n + 2);
            data_ack    = ack_last && (k == n + 2);
        end
        @(negedge sys_clk);
        data_in = 1'b0;
        sample_edge = 1'b0;
        frame_start = 1'b0;
        frame_end = 1'b0;
        data_ack = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        tests_run++;
        if (data_out_m !== 8'h00 || data_ready_m !== 1'b0 || busy_m !== 1'b0 || overrun_m !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_state: got out=%h rdy=%b busy=%b ovr=%b expected 00 0 0 0",
                     data_out_m, data_ready_m, busy_m, overrun_m);
        end
        tests_run++;
        if (data_out_l !== 8'h00 || data_ready_l !== 1'b0 || busy_l !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_state_lsb: got out=%h rdy=%b busy=%b expected 00 0 0",
                     data_out_l, data_ready_l, busy_l);
        end
    endtask

    task automatic test_idle_edges();
        do_reset();
        send(8'hFF, 8, 1'b0, 1'b0, 1'b0);
        tests_run++;
        if (data_ready_m !== 1'b0 || busy_m !== 1'b0 || data_out_m !== 8'h00) begin
            tests_failed++;
            $display("FAIL idle_edges: got rdy=%b busy=%b out=%h expected 0 0 00",
                     data_ready_m, busy_m, data_out_m);
        end
    endtask

    task automatic test_basic();
        do_reset();
        pulse_start();
        tests_run++;
        if (busy_m !== 1'b1) begin
            tests_failed++;
            $display("FAIL busy_rise: got %b expected 1", busy_m);
        end
        send(8'hA5, 8, 1'b0, 1'b0, 1'b0);
        tests_run++;
        if (data_out_m !== 8'hA5 || data_ready_m !== 1'b1) begin
            tests_failed++;
            $display("FAIL basic_msb: got out=%h rdy=%b expected a5 1", data_out_m, data_ready_m);
        end
        tests_run++;
        if (data_out_l !== 8'hA5 || data_ready_l !== 1'b1) begin
            tests_failed++;
            $display("FAIL basic_lsb: got out=%h rdy=%b expected a5 1", data_out_l, data_ready_l);
        end
        pulse_ack();
        tests_run++;
        if (data_ready_m !== 1'b0 || data_out_m !== 8'hA5 || busy_m !== 1'b1) begin
            tests_failed++;
            $display("FAIL basic_ack: got rdy=%b out=%h busy=%b expected 0 a5 1",
                     data_ready_m, data_out_m, busy_m);
        end
        pulse_end();
        tests_run++;
        if (busy_m !== 1'b0 || data_out_m !== 8'hA5) begin
            tests_failed++;
            $display("FAIL basic_end: got busy=%b out=%h expected 0 a5", busy_m, data_out_m);
        end
    endtask

    task automatic test_lsb_first();
        do_reset();
        pulse_start();
        send(8'hC0, 8, 1'b0, 1'b0, 1'b0);
        tests_run++;
        if (data_out_l !== 8'h03) begin
            tests_failed++;
            $display("FAIL lsb_first: got %h expected 03", data_out_l);
        end
        tests_run++;
        if (data_out_m !== 8'hC0) begin
            tests_failed++;
            $display("FAIL msb_first: got %h expected c0", data_out_m);
        end
        pulse_ack();
        pulse_end();
    endtask

    task automatic test_abort();
        do_reset();
        pulse_start();
        send(8'hE1, 8, 1'b0, 1'b0, 1'b0);
        pulse_ack();
        send(8'hF8, 5, 1'b0, 1'b0, 1'b0);
        pulse_end();
        tests_run++;
        if (data_ready_m !== 1'b0 || busy_m !== 1'b0 || data_out_m !== 8'hE1) begin
            tests_failed++;
            $display("FAIL abort_partial: got rdy=%b busy=%b out=%h expected 0 0 e1",
                     data_ready_m, busy_m, data_out_m);
        end
        pulse_start();
        send(8'h3C, 8, 1'b0, 1'b0, 1'b0);
        tests_run++;
        if (data_out_m !== 8'h3C || data_ready_m !== 1'b1) begin
            tests_failed++;
            $display("FAIL abort_next_word: got out=%h rdy=%b expected 3c 1", data_out_m, data_ready_m);
        end
        pulse_ack();
        pulse_end();
    endtask

    task automatic test_overrun();
        do_reset();
        pulse_start();
        send(8'h12, 8, 1'b0, 1'b0, 1'b0);
        send(8'h34, 8, 1'b0, 1'b0, 1'b0);
        tests_run++;
        if (data_out_m !== 8'h34 || data_ready_m !== 1'b1 || overrun_m !== OVR_EXP) begin
            tests_failed++;
            $display("FAIL overrun_set: got out=%h rdy=%b ovr=%b expected 34 1 %b",
                     data_out_m, data_ready_m, overrun_m, OVR_EXP);
        end
        pulse_ack();
        tests_run++;
        if (overrun_m !== OVR_EXP) begin
            tests_failed++;
            $display("FAIL overrun_sticky: got %b expected %b", overrun_m, OVR_EXP);
        end
        do_reset();
        pulse_start();
        send(8'h12, 8, 1'b0, 1'b0, 1'b0);
        send(8'h34, 8, 1'b0, 1'b0, 1'b1);
        tests_run++;
        if (data_out_m !== 8'h34 || data_ready_m !== 1'b1 || overrun_m !== 1'b0) begin
            tests_failed++;
            $display("FAIL overrun_ack_same_cycle: got out=%h rdy=%b ovr=%b expected 34 1 0",
                     data_out_m, data_ready_m, overrun_m);
        end
        pulse_ack();
        pulse_end();
    endtask

    task automatic test_reset_mid();
        do_reset();
        pulse_start();
        send(8'h96, 8, 1'b0, 1'b0, 1'b0);
        send(8'hF0, 4, 1'b0, 1'b0, 1'b0);
        rst = 1'b1;
        #1;
        tests_run++;
        if (data_out_m !== 8'h00 || data_ready_m !== 1'b0 || busy_m !== 1'b0 || overrun_m !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_mid_word: got out=%h rdy=%b busy=%b ovr=%b expected 00 0 0 0",
                     data_out_m, data_ready_m, busy_m, overrun_m);
        end
        @(negedge sys_clk);
        rst = 1'b0;
        send(8'h5A, 8, 1'b0, 1'b0, 1'b0);
        tests_run++;
        if (data_ready_m !== 1'b0 || busy_m !== 1'b0 || data_out_m !== 8'h00) begin
            tests_failed++;
            $display("FAIL reset_then_idle_edges: got rdy=%b busy=%b out=%h expected 0 0 00",
                     data_ready_m, busy_m, data_out_m);
        end
    endtask

    task automatic test_end_with_last();
        do_reset();
        pulse_start();
        send(8'h5A, 8, 1'b0, 1'b1, 1'b0);
        tests_run++;
        if (data_out_m !== 8'h5A || data_ready_m !== 1'b1 || busy_m !== 1'b0) begin
            tests_failed++;
            $display("FAIL end_with_last: got out=%h rdy=%b busy=%b expected 5a 1 0",
                     data_out_m, data_ready_m, busy_m);
        end
        pulse_ack();
    endtask

    task automatic test_restart();
        do_reset();
        pulse_start();
        send(8'hE0, 3, 1'b0, 1'b0, 1'b0);
        send(8'h69, 8, 1'b1, 1'b0, 1'b0);
        tests_run++;
        if (data_out_m !== 8'h69 || data_ready_m !== 1'b1 || busy_m !== 1'b1) begin
            tests_failed++;
            $display("FAIL restart_with_bit: got out=%h rdy=%b busy=%b expected 69 1 1",
                     data_out_m, data_ready_m, busy_m);
        end
        tests_run++;
        if (data_out_l !== 8'h96) begin
            tests_failed++;
            $display("FAIL restart_with_bit_lsb: got %h expected 96", data_out_l);
        end
        pulse_ack();
        pulse_end();
    endtask

    initial begin
        test_reset();
        test_idle_edges();
        test_basic();
        test_lsb_first();
        test_abort();
        test_overrun();
        test_reset_mid();
        test_end_with_last();
        test_restart();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
